uart_tx_serializer: RTL and testbench

Byte-to-serial transmitter for the ICEstick USB3300 sniffer's host link. It accepts one parallel byte per transfer from the capture/packing logic over a valid/ready handshake. It frames the byte as 8N1 (or 8E1 with parity): start bit, data bits LSB first, optional even parity bit, stop bit. It drives the FTDI UART TX pin, with every bit held for a fixed number of master-clock cycles.

---
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: valid/ready byte in, 8N1 frame out on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer #(
    parameter int BAUD_DIV = 104,
    parameter int bits     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] DATA_in,
    input  logic            valid,
    output logic            ready,
    output logic            tx,
    output logic            done
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(bits + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(bits - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t          state_q;
    logic [CW-1:0]   baud_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic [bits-1:0] shreg_q;
    logic [bits-1:0] shreg_shr_d;
    logic            tx_q;
    logic            ready_q;
    logic            done_q;
    logic            bit_end_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    assign bit_end_d   = (baud_cnt_q == BAUD_LAST);
    assign shreg_shr_d = shreg_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                baud_cnt_q <= bit_end_d ? '0 : baud_cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        shreg_q    <= DATA_in;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^DATA_in;
`endif
                        state_q    <= S_START;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end_d) begin
                        state_q <= S_DATA;
                        tx_q    <= shreg_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_d) begin
                        shreg_q <= shreg_shr_d;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= S_PARITY;
                            tx_q      <= parity_q;
`else
                            state_q   <= S_STOP;
                            tx_q      <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shreg_shr_d[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end_d) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // done and ready rise together so a held valid is taken on the very next edge
                    if (bit_end_d) begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    baud_cnt_q <= '0;
                    tx_q       <= 1'b1;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at BAUD_DIV=4; table of frames plus corner sequences.
module tb_uart_tx_serializer;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // bit i = tx level during bit period i
    } vec_t;

    vec_t vecs [6];

    uart_tx_serializer #(.BAUD_DIV(B), .bits(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .DATA_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at sample time with the DUT idle; returns just after the accept edge.
    task automatic send_accept(input logic [7:0] d);
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", {31'd0, ready}, 32'd1);
        data_in = d;
        valid   = 1'b1;
        @(posedge clk);
    endtask

    // Checks a whole frame from the accept edge to the done cycle.
    task automatic run_frame(input logic [10:0] exp, input int glitch_cyc,
                             input logic [7:0] glitch_data, input bit hold_valid);
        for (int c = 1; c <= FRAME_CYC; c++) begin
            #1;
            if (c == 1 && !hold_valid) valid = 1'b0;
            if (c == glitch_cyc) begin
                data_in = glitch_data;
                valid   = 1'b1;
            end
            if (c == glitch_cyc + 1 && !hold_valid) valid = 1'b0;
            chk("frame_tx",    {31'd0, tx},    {31'd0, exp[(c-1)/B]});
            chk("frame_ready", {31'd0, ready}, 32'd0);
            chk("frame_done",  {31'd0, done},  32'd0);
            @(posedge clk);
        end
        #1;
        chk("end_done",  {31'd0, done},  32'd1);
        chk("end_ready", {31'd0, ready}, 32'd1);
        chk("end_tx",    {31'd0, tx},    32'd1);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_tx",    {31'd0, tx},    32'd1);
            chk("idle_ready", {31'd0, ready}, 32'd1);
            chk("idle_done",  {31'd0, done},  32'd0);
        end
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0};
        vecs[2] = '{8'h3C, 11'b1_0_00111100_0};
        vecs[3] = '{8'h01, 11'b1_1_00000001_0};
        vecs[4] = '{8'hFE, 11'b1_1_11111110_0};
        vecs[5] = '{8'h80, 11'b1_1_10000000_0};
`else
        vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
        vecs[1] = '{8'h07, 11'b0_1_00000111_0};
        vecs[2] = '{8'h3C, 11'b0_1_00111100_0};
        vecs[3] = '{8'h01, 11'b0_1_00000001_0};
        vecs[4] = '{8'hFE, 11'b0_1_11111110_0};
        vecs[5] = '{8'h80, 11'b0_1_10000000_0};
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_tx",    {31'd0, tx},    32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done",  {31'd0, done},  32'd0);
        idle_check(50);
        $display("idle 50 cycles after reset checked");

        for (int v = 0; v < 6; v++) begin
            send_accept(vecs[v].data);
            run_frame(vecs[v].frame, 0, 8'h00, 1'b0);
            idle_check(2);
            $display("frame data=%02h sent", vecs[v].data);
        end

        // Back-to-back with valid held: 0x00 then 0xFF after a single handshake cycle.
        send_accept(8'h00);
`ifdef UART_TX_PARITY_EN
        run_frame(11'b1_0_00000000_0, 1, 8'hFF, 1'b1);
        chk("b2b_accept", {31'd0, ready}, 32'd1);
        @(posedge clk);
        valid = 1'b1;
        run_frame(11'b1_0_11111111_0, 0, 8'h00, 1'b0);
`else
        run_frame(11'b0_1_00000000_0, 1, 8'hFF, 1'b1);
        chk("b2b_accept", {31'd0, ready}, 32'd1);
        @(posedge clk);
        run_frame(11'b0_1_11111111_0, 0, 8'h00, 1'b0);
`endif
        idle_check(2);
        $display("back-to-back frames 00,FF sent");

        // DATA_in change plus valid pulse mid-frame must not disturb the frame.
        send_accept(8'hA5);
        run_frame(vecs[0].frame, 15, 8'h00, 1'b0);
        idle_check(2);
        $display("mid-frame valid pulse ignored");

        // Reset during data bit 3 (cycles 17..20) abandons the frame.
        send_accept(8'hC3);
        for (int c = 1; c <= 18; c++) begin
            #1;
            if (c == 1) valid = 1'b0;
            chk("prerst_tx", {31'd0, tx}, {31'd0, (11'b1_11000011_0 >> ((c-1)/B)) & 11'd1});
            if (c == 18) rst = 1'b1;
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        chk("midrst_tx",    {31'd0, tx},    32'd1);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_done",  {31'd0, done},  32'd0);
        idle_check(FRAME_CYC);
        send_accept(8'h3C);
        run_frame(vecs[2].frame, 0, 8'h00, 1'b0);
        idle_check(1);
        $display("reset mid-frame then 3C sent");

        // Reset together with valid: no transfer.
        rst     = 1'b1;
        valid   = 1'b1;
        data_in = 8'h55;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b0;
        chk("rstvalid_ready", {31'd0, ready}, 32'd1);
        chk("rstvalid_tx",    {31'd0, tx},    32'd1);
        idle_check(3);
        $display("reset with valid: no transfer");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
